// File: rtl/intersections_pkg.sv
// -----------------------------------------------------------------------------
// intersections_pkg
// Shared types and width helpers for the sequential two-circle intersection
// block (intersections_seq) and its serial divider.
//   - state_t         : top-level FSM states
//   - f_* functions   : datapath widths as functions of the coordinate width N
//   - ROUND_EN        : quotient rounding mode, taken from the optional macro
//                       INTERSECTIONS_ROUND_EN (defined: round to nearest with
//                       halves away from zero; undefined: truncate toward zero)
// -----------------------------------------------------------------------------
package intersections_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CHECK,
    ST_SQRT,
    ST_NUM,
    ST_DIV,
    ST_DONE
  } state_t;

  // Square-root result bits, one per SQRT cycle.
  function automatic int f_ws(input int n);
    return 2 * n + 3;
  endfunction

  // Quotient bits, one per divider cycle.
  function automatic int f_wq(input int n);
    return n + 2;
  endfunction

  // A = rK^2 - rL^2 + D.
  function automatic int f_aw(input int n);
    return 2 * n + 4;
  endfunction

  // disc = 4*rK^2*D - A^2.
  function automatic int f_discw(input int n);
    return 4 * n + 8;
  endfunction

  // A*dx +/- H*dy style numerators.
  function automatic int f_numw(input int n);
    return 3 * n + 6;
  endfunction

`ifdef INTERSECTIONS_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

endpackage

// File: rtl/intersections_serial_div.sv
// -----------------------------------------------------------------------------
// intersections_serial_div
// Unsigned restoring divider, one quotient bit per cycle, QW cycles per
// division. The caller guarantees the quotient fits in QW bits, i.e.
// i_dividend < i_divisor * 2^QW, so the upper NW-QW dividend bits are already
// smaller than the divisor and can seed the partial remainder directly.
// NW - QW is expected to be DW + 1.
// Ports:
//   clk, rst    clock, synchronous active-high reset (control only)
//   i_start     load operands and perform the first step this edge
//   i_dividend  NW-bit unsigned dividend
//   i_divisor   DW-bit unsigned divisor (sampled on i_start)
//   o_busy      steps remaining after the current edge
//   o_done      one-cycle pulse: o_quot holds the finished quotient
//   o_quot      QW-bit quotient
// -----------------------------------------------------------------------------
module intersections_serial_div #(
  parameter int NW = 30,
  parameter int DW = 19,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [NW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [QW-1:0] o_quot
);

  localparam int RW = NW - QW;
  localparam int CW = $clog2(QW);

  logic [RW-1:0] r_rem;
  // Low dividend bits shift out of the top while quotient bits shift in.
  logic [QW-1:0] r_low;
  logic [DW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [RW-1:0] w_rem_src;
  logic [QW-1:0] w_low_src;
  logic [RW:0]   w_try;
  logic [RW:0]   w_dvs;
  logic          w_ge;

  // The first step runs straight from the inputs so a division takes exactly
  // QW edges starting with the i_start edge.
  always_comb begin
    if (i_start) begin
      w_rem_src = i_dividend[NW-1:QW];
      w_low_src = i_dividend[QW-1:0];
      w_dvs     = (RW + 1)'(i_divisor);
    end else begin
      w_rem_src = r_rem;
      w_low_src = r_low;
      w_dvs     = (RW + 1)'(r_dvs);
    end
    w_try = {w_rem_src, w_low_src[QW-1]};
    w_ge  = (w_try >= w_dvs);
  end

  always_ff @(posedge clk) begin
    if (i_start || r_busy) begin
      r_rem <= RW'(w_ge ? (w_try - w_dvs) : w_try);
      r_low <= {w_low_src[QW-2:0], w_ge};
    end
    if (i_start) begin
      r_dvs <= i_divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(1);
      end else if (r_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(QW - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_low;

endmodule

// File: rtl/intersections_seq.sv
// -----------------------------------------------------------------------------
// intersections_seq
// Handshaked two-circle intersection. Circle K (xK,yK,rK) and circle L
// (xL,yL,rL) are captured, then both intersection points are computed with a
// bit-serial integer square root (inline) and one shared serial divider that
// is reused for the four coordinate quotients.
// Optional build macro: INTERSECTIONS_ROUND_EN (round quotients to nearest,
// halves away from zero); default build truncates toward zero.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = FSM in IDLE)
//   xK, yK, xL, yL       N-bit signed centres
//   rK, rL               N+1-bit non-negative radii
//   out_valid/out_ready  result handshake, result held until accepted
//   x1P, y1P, x2P, y2P   N+2-bit signed intersection points
//   no_int               disjoint, contained or concentric circles
//   tangent              single touch point, both points equal
// -----------------------------------------------------------------------------
module intersections_seq
  import intersections_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] xK,
  input  logic signed [N-1:0] yK,
  input  logic signed [N-1:0] xL,
  input  logic signed [N-1:0] yL,
  input  logic signed [N:0]   rK,
  input  logic signed [N:0]   rL,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N+1:0] x1P,
  output logic signed [N+1:0] y1P,
  output logic signed [N+1:0] x2P,
  output logic signed [N+1:0] y2P,
  output logic                no_int,
  output logic                tangent
);

  localparam int DW    = 2 * N + 2;
  localparam int AW    = f_aw(N);
  localparam int DISCW = f_discw(N);
  localparam int WS    = f_ws(N);
  localparam int RW    = WS + 2;
  localparam int NUMW  = f_numw(N);
  localparam int WQ    = f_wq(N);
  localparam int PW    = N + 2;
  localparam int CNTW  = $clog2(WS);

  state_t r_state;
  state_t w_next;

  logic signed [N-1:0]  r_xk, r_yk, r_xl, r_yl;
  logic signed [N:0]    r_rk, r_rl;
  logic signed [N:0]    r_dx, r_dy;
  logic [DW-1:0]        r_d;
  logic signed [AW-1:0] r_a, r_rksq;
  logic [2*WS-1:0]      r_rad;
  logic [RW-1:0]        r_rem;
  logic [WS-1:0]        r_root;
  logic [CNTW-1:0]      r_cnt;
  logic [1:0]           r_idx;
  logic signed [PW-1:0] r_x1, r_y1, r_x2, r_y2;
  logic                 r_no_int, r_tangent;

  logic signed [N:0]       w_dx, w_dy;
  logic signed [DW-1:0]    w_dx_d, w_dy_d;
  logic [DW-1:0]           w_d;
  logic signed [AW-1:0]    w_rk_a, w_rl_a, w_rksq, w_rlsq, w_a;
  logic signed [DISCW-1:0] w_rksq_x, w_d_x, w_a_x, w_disc;
  logic                    w_no_int;
  logic [RW+1:0]           w_sq_try, w_sq_trial;
  logic                    w_sq_ge;
  logic signed [NUMW-1:0]  w_a_n, w_dx_n, w_dy_n, w_h_n;
  logic signed [NUMW-1:0]  w_adx, w_ady, w_hdx, w_hdy;
  logic signed [NUMW-1:0]  w_num [4];
  logic [1:0]              w_div_sel;
  logic signed [NUMW-1:0]  w_sel_num;
  logic [NUMW-1:0]         w_sel_mag, w_dividend;
  logic                    w_div_start, w_div_busy, w_div_done;
  logic [WQ-1:0]           w_quot;
  logic                    w_res_neg;
  logic signed [PW-1:0]    w_base, w_qs, w_point;

  // ---- PREP: deltas, squared distance, A, rK^2 ----
  always_comb begin
    w_dx   = {r_xl[N-1], r_xl} - {r_xk[N-1], r_xk};
    w_dy   = {r_yl[N-1], r_yl} - {r_yk[N-1], r_yk};
    w_dx_d = DW'(w_dx);
    w_dy_d = DW'(w_dy);
    w_d    = w_dx_d * w_dx_d + w_dy_d * w_dy_d;
    w_rk_a = AW'(r_rk);
    w_rl_a = AW'(r_rl);
    w_rksq = w_rk_a * w_rk_a;
    w_rlsq = w_rl_a * w_rl_a;
    w_a    = w_rksq - w_rlsq + $signed(AW'(w_d));
  end

  // ---- CHECK: discriminant and no-intersection decision ----
  always_comb begin
    w_rksq_x = DISCW'(r_rksq);
    w_d_x    = $signed(DISCW'(r_d));
    w_a_x    = DISCW'(r_a);
    w_disc   = ((w_rksq_x * w_d_x) <<< 2) - (w_a_x * w_a_x);
    w_no_int = (r_d == '0) || (w_disc < 0);
  end

  // ---- SQRT: one root bit per cycle, two radicand bits consumed ----
  always_comb begin
    w_sq_try   = {r_rem, r_rad[2*WS-1 -: 2]};
    w_sq_trial = {2'b00, r_root, 2'b01};
    w_sq_ge    = (w_sq_try >= w_sq_trial);
  end

  // ---- NUM/DIV: numerators, magnitude into the divider, sign back out ----
  always_comb begin
    w_a_n  = NUMW'(r_a);
    w_dx_n = NUMW'(r_dx);
    w_dy_n = NUMW'(r_dy);
    w_h_n  = $signed(NUMW'(r_root));
    w_adx  = w_a_n * w_dx_n;
    w_ady  = w_a_n * w_dy_n;
    w_hdx  = w_h_n * w_dx_n;
    w_hdy  = w_h_n * w_dy_n;
    w_num[0] = w_adx - w_hdy;
    w_num[1] = w_ady + w_hdx;
    w_num[2] = w_adx + w_hdy;
    w_num[3] = w_ady - w_hdx;
  end

  always_comb begin
    w_sel_num = w_num[w_div_sel];
    w_sel_mag = w_sel_num[NUMW-1] ? -w_sel_num : w_sel_num;
    // Adding D before dividing by 2D turns truncation into round-half-away.
    if (ROUND_EN) begin
      w_dividend = w_sel_mag + NUMW'(r_d);
    end else begin
      w_dividend = w_sel_mag;
    end
  end

  intersections_serial_div #(
    .NW (NUMW),
    .DW (DW + 1),
    .QW (WQ)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  ({r_d, 1'b0}),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // Quotient r_idx belongs to numerator r_idx; even indices are x, odd are y.
  always_comb begin
    w_res_neg = w_num[r_idx][NUMW-1];
    w_base    = r_idx[0] ? PW'(r_yk) : PW'(r_xk);
    w_qs      = w_res_neg ? -$signed(w_quot) : $signed(w_quot);
    w_point   = w_base + w_qs;
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    w_div_sel   = r_idx + 2'd1;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next = ST_PREP;
      ST_PREP:  w_next = ST_CHECK;
      ST_CHECK: w_next = w_no_int ? ST_DONE : ST_SQRT;
      ST_SQRT:  if (r_cnt == CNTW'(WS - 1)) w_next = ST_NUM;
      ST_NUM: begin
        w_div_start = 1'b1;
        w_div_sel   = 2'd0;
        w_next      = ST_DIV;
      end
      ST_DIV: begin
        // Next division starts on the same cycle the previous one reports
        // done, so the four divisions run back to back.
        if (w_div_done && !w_div_busy) begin
          if (r_idx == 2'd3) begin
            w_next = ST_DONE;
          end else begin
            w_div_start = 1'b1;
          end
        end
      end
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && in_valid && !rst) begin
      r_xk <= xK;
      r_yk <= yK;
      r_xl <= xL;
      r_yl <= yL;
      r_rk <= rK;
      r_rl <= rL;
    end
    if (r_state == ST_PREP) begin
      r_dx   <= w_dx;
      r_dy   <= w_dy;
      r_d    <= w_d;
      r_a    <= w_a;
      r_rksq <= w_rksq;
    end
    if (r_state == ST_CHECK) begin
      r_rad  <= w_disc[2*WS-1:0];
      r_rem  <= '0;
      r_root <= '0;
    end
    if (r_state == ST_SQRT) begin
      r_rad  <= {r_rad[2*WS-3:0], 2'b00};
      r_rem  <= RW'(w_sq_ge ? (w_sq_try - w_sq_trial) : w_sq_try);
      r_root <= {r_root[WS-2:0], w_sq_ge};
    end
  end

  // ---- Sequencing counters and result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_x2      <= '0;
      r_y2      <= '0;
      r_no_int  <= 1'b0;
      r_tangent <= 1'b0;
    end else begin
      case (r_state)
        ST_CHECK: begin
          r_cnt     <= '0;
          r_idx     <= '0;
          r_no_int  <= w_no_int;
          r_tangent <= 1'b0;
          if (w_no_int) begin
            r_x1 <= '0;
            r_y1 <= '0;
            r_x2 <= '0;
            r_y2 <= '0;
          end
        end
        ST_SQRT: r_cnt <= r_cnt + 1'b1;
        ST_NUM:  r_tangent <= (r_root == '0);
        ST_DIV: begin
          if (w_div_done && !w_div_busy) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0:    r_x1 <= w_point;
              2'd1:    r_y1 <= w_point;
              2'd2:    r_x2 <= w_point;
              default: r_y2 <= w_point;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign x1P       = r_x1;
  assign y1P       = r_y1;
  assign x2P       = r_x2;
  assign y2P       = r_y2;
  assign no_int    = r_no_int;
  assign tangent   = r_tangent;

endmodule
